control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_pkg.sv | 64 ++++++
 rtl/control_sequencer_op_decode.sv | 31 +++
 rtl/control_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared definitions for the control sequencer: instruction-register field
//   positions, opcode constants, register-field select codes, the state
//   enumeration and the opcode classification used by op_decode.
//   Build option: MUL_DIV_EN adds the MUL/DIV sequence and the T6 state.
package control_sequencer_pkg;

  localparam int IR_W    = 32;
  localparam int OPC_W   = 5;

  // Instruction register field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Opcodes
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  // One-hot {Gra, Grb, Grc} register-field select
  localparam logic [2:0] GSEL_RA = 3'b100;
  localparam logic [2:0] GSEL_RB = 3'b010;
  localparam logic [2:0] GSEL_RC = 3'b001;

  typedef enum logic [2:0] {
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
`ifdef MUL_DIV_EN
    ST_T6,
`endif
    ST_HALTED
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,     // NOP and every undefined opcode
    CLS_THREE,   // ra <- rb op rc
    CLS_UNARY,   // ra <- op rb
    CLS_MULDIV,  // {HI,LO} <- ra op rb
    CLS_HALT
  } op_class_e;

  // The ALU operation code is the low four opcode bits.
  function automatic logic [3:0] alu_op(input logic [OPC_W-1:0] opc);
    return opc[3:0];
  endfunction

endpackage

// File: rtl/control_sequencer_op_decode.sv
// op_decode
//   Classifies a 5-bit opcode into the instruction families the sequencer
//   walks through: three-register, unary, multiply/divide, nop, halt.
//   Build option: without MUL_DIV_EN, MUL and DIV classify as NOP.
//   Ports:
//     opcode   in  [4:0]  opcode to classify
//     op_class out        instruction family
module op_decode
  import control_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_e        op_class
);

  always_comb begin
    op_class = CLS_NOP;
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: op_class = CLS_THREE;
      OPC_NEG, OPC_NOT:                  op_class = CLS_UNARY;
`ifdef MUL_DIV_EN
      OPC_MUL, OPC_DIV:                  op_class = CLS_MULDIV;
`else
      OPC_MUL, OPC_DIV:                  op_class = CLS_NOP;
`endif
      OPC_HALT:                          op_class = CLS_HALT;
      OPC_NOP:                           op_class = CLS_NOP;
      default:                           op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore control unit for a single-bus datapath. Fetches (T0..T2), then
//   sequences the execute phase by opcode class. HALT parks in HALTED until
//   clear. Build option: MUL_DIV_EN enables MUL/DIV (T3..T6, Z high, HI/LO).
//   Ports:
//     Clock     in       rising-edge clock
//     clear     in       asynchronous active-low reset
//     ir        in  [31] instruction register (opcode ir[31:27])
//     mem_done  in       memory read complete, sampled in T1
//     halted    out      high in HALTED
//     PCout..Zhighout, Rin, Rout, HIin, LOin  out  datapath strobes
//     gsel      out [3]  one-hot {Gra,Grb,Grc}
//     operation out [4]  ALU operation, 0 when not executing
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic            Clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            mem_done,
  output logic            halted,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            Read,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin_low,
  output logic            Zin_high,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic [2:0]      gsel,
  output logic            Rin,
  output logic            Rout,
  output logic            HIin,
  output logic            LOin,
  output logic [3:0]      operation
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  logic             t1_wait_q, t1_wait_d;
  logic [OPC_W-1:0] opcode_cur;
  op_class_e        op_class;

  // IR is loaded at the end of T2, so during T3 the opcode comes straight
  // from ir; from T4 on the captured copy is used so the datapath may change
  // ir without disturbing the running instruction.
  assign opcode_cur = (state_q == ST_T3) ? ir[OPC_MSB:OPC_LSB] : opcode_q;

  // Register fields are consumed by the datapath, not by the sequencer.
  logic unused_ir;
  assign unused_ir = ^{ir[RA_MSB:RA_LSB], ir[RB_MSB:RB_LSB],
                       ir[RC_MSB:RC_LSB], ir[RC_LSB-1:0]};

  op_decode u_op_decode (
    .opcode   (opcode_cur),
    .op_class (op_class)
  );

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values of the others, matching real hardware.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_T0;
      opcode_q  <= '0;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  // Next-state logic
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    // High on every T1 cycle after the first, gating PCin to one pulse.
    t1_wait_d = (state_q == ST_T1);

    case (state_q)
      ST_T0: state_d = ST_T1;
      ST_T1: state_d = mem_done ? ST_T2 : ST_T1;
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        opcode_d = ir[OPC_MSB:OPC_LSB];
        case (op_class)
          CLS_THREE, CLS_UNARY: state_d = ST_T4;
`ifdef MUL_DIV_EN
          CLS_MULDIV:           state_d = ST_T4;
`endif
          CLS_HALT:             state_d = ST_HALTED;
          default:              state_d = ST_T0;
        endcase
      end
      ST_T4: begin
        case (op_class)
          CLS_THREE:  state_d = ST_T5;
`ifdef MUL_DIV_EN
          CLS_MULDIV: state_d = ST_T5;
`endif
          default:    state_d = ST_T0;
        endcase
      end
      ST_T5: begin
`ifdef MUL_DIV_EN
        state_d = (op_class == CLS_MULDIV) ? ST_T6 : ST_T0;
`else
        state_d = ST_T0;
`endif
      end
`ifdef MUL_DIV_EN
      ST_T6:     state_d = ST_T0;
`endif
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_T0;
    endcase
  end

  // Output decode (state plus the instruction being executed)
  always_comb begin
    halted    = 1'b0;
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    Read      = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin_low   = 1'b0;
    Zin_high  = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    gsel      = 3'b000;
    Rin       = 1'b0;
    Rout      = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    operation = 4'b0000;

    case (state_q)
      ST_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin_low = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = ~t1_wait_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (op_class)
          CLS_THREE: begin
            gsel = GSEL_RB;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          CLS_UNARY: begin
            gsel      = GSEL_RB;
            Rout      = 1'b1;
            Zin_low   = 1'b1;
            operation = alu_op(opcode_cur);
          end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin
            gsel = GSEL_RA;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      ST_T4: begin
        case (op_class)
          CLS_THREE: begin
            gsel      = GSEL_RC;
            Rout      = 1'b1;
            Zin_low   = 1'b1;
            operation = alu_op(opcode_cur);
          end
          CLS_UNARY: begin
            Zlowout = 1'b1;
            gsel    = GSEL_RA;
            Rin     = 1'b1;
          end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin
            gsel      = GSEL_RB;
            Rout      = 1'b1;
            Zin_low   = 1'b1;
            Zin_high  = 1'b1;
            operation = alu_op(opcode_cur);
          end
`endif
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_class)
          CLS_THREE: begin
            Zlowout = 1'b1;
            gsel    = GSEL_RA;
            Rin     = 1'b1;
          end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
`endif
          default: ;
        endcase
      end
`ifdef MUL_DIV_EN
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
`endif
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Directed bench for control_sequencer. Each stimulus step pushes the
//   expected output vector for that cycle onto a scoreboard queue; a monitor
//   pops and compares it mid-cycle on the falling edge.
//   Honours MUL_DIV_EN the same way the design does.
module tb_control_sequencer;

  typedef struct packed {
    logic       halted;
    logic       PCout;
    logic       PCin;
    logic       IncPC;
    logic       MARin;
    logic       MDRin;
    logic       MDRout;
    logic       Read;
    logic       IRin;
    logic       Yin;
    logic       Zin_low;
    logic       Zin_high;
    logic       Zlowout;
    logic       Zhighout;
    logic [2:0] gsel;
    logic       Rin;
    logic       Rout;
    logic       HIin;
    logic       LOin;
    logic [3:0] operation;
  } out_t;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_done;
  logic        halted, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic        Yin, Zin_low, Zin_high, Zlowout, Zhighout, Rin, Rout, HIin, LOin;
  logic [2:0]  gsel;
  logic [3:0]  operation;

  out_t        observed;
  out_t        exp_cur;
  string       tag_cur;
  out_t        exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock     (Clock),
    .clear     (clear),
    .ir        (ir),
    .mem_done  (mem_done),
    .halted    (halted),
    .PCout     (PCout),
    .PCin      (PCin),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .Read      (Read),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zin_low   (Zin_low),
    .Zin_high  (Zin_high),
    .Zlowout   (Zlowout),
    .Zhighout  (Zhighout),
    .gsel      (gsel),
    .Rin       (Rin),
    .Rout      (Rout),
    .HIin      (HIin),
    .LOin      (LOin),
    .operation (operation)
  );

  assign observed = {halted, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read,
                     IRin, Yin, Zin_low, Zin_high, Zlowout, Zhighout, gsel,
                     Rin, Rout, HIin, LOin, operation};

  // Compare the current outputs against one expected vector.
  task automatic check(input out_t e, input string tag);
    n_cmp++;
    if (observed !== e) begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, e);
    end
  endtask

  // Scoreboard monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge Clock) begin
    if (exp_q.size() != 0) begin
      exp_cur = exp_q.pop_front();
      tag_cur = tag_q.pop_front();
      check(exp_cur, tag_cur);
    end
  end

  // Expected output vectors, written from the state table.
  function automatic out_t e_blank();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t e_t0();
    out_t o = '0;
    o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.Zin_low = 1'b1;
    return o;
  endfunction

  function automatic out_t e_t1(input logic first);
    out_t o = '0;
    o.Zlowout = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1; o.PCin = first;
    return o;
  endfunction

  function automatic out_t e_t2();
    out_t o = '0;
    o.MDRout = 1'b1; o.IRin = 1'b1;
    return o;
  endfunction

  function automatic out_t e_rb_to_y();
    out_t o = '0;
    o.gsel = 3'b010; o.Rout = 1'b1; o.Yin = 1'b1;
    return o;
  endfunction

  function automatic out_t e_rc_alu(input logic [3:0] op);
    out_t o = '0;
    o.gsel = 3'b001; o.Rout = 1'b1; o.Zin_low = 1'b1; o.operation = op;
    return o;
  endfunction

  function automatic out_t e_rb_unary(input logic [3:0] op);
    out_t o = '0;
    o.gsel = 3'b010; o.Rout = 1'b1; o.Zin_low = 1'b1; o.operation = op;
    return o;
  endfunction

  function automatic out_t e_wb_ra();
    out_t o = '0;
    o.Zlowout = 1'b1; o.gsel = 3'b100; o.Rin = 1'b1;
    return o;
  endfunction

  function automatic out_t e_halted();
    out_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

`ifdef MUL_DIV_EN
  function automatic out_t e_md_t3();
    out_t o = '0;
    o.gsel = 3'b100; o.Rout = 1'b1; o.Yin = 1'b1;
    return o;
  endfunction

  function automatic out_t e_md_t4(input logic [3:0] op);
    out_t o = '0;
    o.gsel = 3'b010; o.Rout = 1'b1; o.Zin_low = 1'b1; o.Zin_high = 1'b1;
    o.operation = op;
    return o;
  endfunction

  function automatic out_t e_md_t5();
    out_t o = '0;
    o.Zlowout = 1'b1; o.LOin = 1'b1;
    return o;
  endfunction

  function automatic out_t e_md_t6();
    out_t o = '0;
    o.Zhighout = 1'b1; o.HIin = 1'b1;
    return o;
  endfunction
`endif

  // Instruction word with ra=1, rb=2, rc=3.
  function automatic logic [31:0] mk_ir(input logic [4:0] opc);
    return {opc, 27'h0918000};
  endfunction

  // One cycle: queue the expectation, then advance to just past the next edge.
  task automatic step(input out_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge Clock);
    #1;
  endtask

  // Fetch: T0, T1 (with `waits` extra cycles of mem_done low), T2.
  task automatic fetch(input logic [31:0] instr, input int waits, input string tag);
    ir       = instr;
    mem_done = 1'b1;
    step(e_t0(), {tag, "_t0"});
    for (int k = 0; k <= waits; k++) begin
      mem_done = (k == waits);
      step(e_t1(k == 0), $sformatf("%s_t1_%0d", tag, k));
    end
    mem_done = 1'b1;
    step(e_t2(), {tag, "_t2"});
  endtask

  initial begin
    clear    = 1'b0;
    ir       = 32'h0;
    mem_done = 1'b1;
    #1;
    check(e_t0(), "reset_state");
    @(posedge Clock);
    #1;

    // Reset holds T0; the first cycle after release is still T0.
    step(e_t0(), "reset_low");
    clear = 1'b1;

    // ADD R1,R2,R3 with no memory wait: six cycles T0..T5.
    fetch(32'h18918000, 0, "add");
    step(e_rb_to_y(), "add_t3");
    step(e_rc_alu(4'b0011), "add_t4");
    step(e_wb_ra(), "add_t5");

    // SUB with three wait cycles; ir changes after T3 to prove the opcode
    // is held internally.
    fetch(mk_ir(5'b00100), 3, "sub");
    step(e_rb_to_y(), "sub_t3");
    ir = 32'h0;
    step(e_rc_alu(4'b0100), "sub_t4_held");
    step(e_wb_ra(), "sub_t5");

    // Unary ops
    fetch(mk_ir(5'b10010), 0, "not");
    step(e_rb_unary(4'b0010), "not_t3");
    step(e_wb_ra(), "not_t4");
    fetch(mk_ir(5'b10001), 1, "neg");
    step(e_rb_unary(4'b0001), "neg_t3");
    step(e_wb_ra(), "neg_t4");

    // NOP and an undefined opcode return to T0 from T3 with no write.
    fetch(mk_ir(5'b11010), 0, "nop");
    step(e_blank(), "nop_t3");
    fetch(mk_ir(5'b11111), 0, "undef");
    step(e_blank(), "undef_t3");

    // MUL: full sequence when enabled, undefined otherwise.
    fetch(mk_ir(5'b01111), 0, "mul");
`ifdef MUL_DIV_EN
    step(e_md_t3(), "mul_t3");
    step(e_md_t4(4'b1111), "mul_t4");
    step(e_md_t5(), "mul_t5");
    step(e_md_t6(), "mul_t6");
    fetch(mk_ir(5'b10000), 0, "div");
    step(e_md_t3(), "div_t3");
    step(e_md_t4(4'b0000), "div_t4");
    step(e_md_t5(), "div_t5");
    step(e_md_t6(), "div_t6");
`else
    step(e_blank(), "mul_undef_t3");
    fetch(mk_ir(5'b10000), 0, "div");
    step(e_blank(), "div_undef_t3");
`endif

    // Clear asserted during T4 of AND forces T0 within the same cycle.
    fetch(mk_ir(5'b00101), 0, "and");
    step(e_rb_to_y(), "and_t3");
    clear = 1'b0;
    step(e_t0(), "clear_in_t4");
    clear = 1'b1;

    // OR runs normally after the mid-instruction clear.
    fetch(mk_ir(5'b00110), 0, "or");
    step(e_rb_to_y(), "or_t3");
    step(e_rc_alu(4'b0110), "or_t4");
    step(e_wb_ra(), "or_t5");

    // HALT parks in HALTED for 20 cycles, mem_done toggling ignored.
    fetch(mk_ir(5'b11011), 0, "halt");
    step(e_blank(), "halt_t3");
    for (int k = 0; k < 20; k++) begin
      mem_done = k[0];
      step(e_halted(), $sformatf("halted_%0d", k));
    end
    check(e_halted(), "halted_after_wait");
    mem_done = 1'b1;
    clear = 1'b0;
    step(e_t0(), "halt_clear");
    clear = 1'b1;
    step(e_t0(), "post_halt_t0");
    step(e_t1(1'b1), "post_halt_t1");

    @(negedge Clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
